// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ID/EX bundle types.
// Imported by the ID/EX boundary and its hazard unit.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] aluop;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       funct7_5;
    } id_ex_data_t;

    // R-type and stores read rs2; immediate forms do not.
    function automatic logic uses_rs2(input logic alusrc,
                                      input logic memwrite);
        return !alusrc | memwrite;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detection between the ID instruction and the load in EX.
// Purely combinational.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_alusrc,
    input  logic       i_id_memwrite,
    input  logic       i_ex_valid,
    input  logic       i_ex_memread,
    input  logic       i_ex_regwrite,
    input  logic [4:0] i_ex_rd,
    output logic       o_uses_rs2,
    output logic       o_load_use
);

    logic w_ex_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign o_uses_rs2 = uses_rs2(i_id_alusrc, i_id_memwrite);

    assign w_ex_load = i_ex_valid & i_ex_memread & i_ex_regwrite
                     & (i_ex_rd != 5'd0);
    assign w_rs1_hit = (i_ex_rd == i_id_rs1);
    assign w_rs2_hit = o_uses_rs2 & (i_ex_rd == i_id_rs2);

    assign o_load_use = i_id_valid & w_ex_load & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, EX backpressure,
// branch flush and a saturating stall-cycle counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7_5,
    input  logic             id_alusrc,
    input  logic             id_memtoreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic [1:0]       id_aluop,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7_5,
    output logic             ex_alusrc,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic [1:0]       ex_aluop,
    output logic             id_stall,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    id_ex_ctrl_t      r_ctrl;
    id_ex_data_t      r_data;
    logic [CNT_W-1:0] r_stall_cnt;

    id_ex_ctrl_t w_id_ctrl;
    id_ex_data_t w_id_data;
    logic        w_advance;
    logic        w_load_use;
    logic        w_uses_rs2;
    logic        w_bubble;
    logic        w_cnt_max;

    assign w_id_ctrl = '{alusrc:   id_alusrc,
                         memtoreg: id_memtoreg,
                         regwrite: id_regwrite,
                         memread:  id_memread,
                         memwrite: id_memwrite,
                         aluop:    id_aluop};

    assign w_id_data = '{rs1:      id_rs1,
                         rs2:      id_rs2,
                         rd:       id_rd,
                         funct3:   id_funct3,
                         funct7_5: id_funct7_5};

    hazard_detect u_hazard (
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_alusrc   (id_alusrc),
        .i_id_memwrite (id_memwrite),
        .i_ex_valid    (r_valid),
        .i_ex_memread  (r_ctrl.memread),
        .i_ex_regwrite (r_ctrl.regwrite),
        .i_ex_rd       (r_data.rd),
        .o_uses_rs2    (w_uses_rs2),
        .o_load_use    (w_load_use)
    );

    assign w_advance = !r_valid | ex_ready;
    assign w_bubble  = flush | w_load_use | !id_valid;
    assign id_stall  = !flush & id_valid & (w_load_use | !w_advance);
    assign w_cnt_max = &r_stall_cnt;

    // Bubbles zero every field so no side effect can leak into EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_ctrl     <= '0;
            r_data     <= '0;
        end else if (w_advance) begin
            if (w_bubble) begin
                r_valid    <= 1'b0;
                r_pc       <= '0;
                r_rs1_data <= '0;
                r_rs2_data <= '0;
                r_imm      <= '0;
                r_ctrl     <= '0;
                r_data     <= '0;
            end else begin
                r_valid    <= 1'b1;
                r_pc       <= id_pc;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm      <= id_imm;
                r_ctrl     <= w_id_ctrl;
                r_data     <= w_id_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (id_stall && !w_cnt_max) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_rs1       = r_data.rs1;
    assign ex_rs2       = r_data.rs2;
    assign ex_rd        = r_data.rd;
    assign ex_funct3    = r_data.funct3;
    assign ex_funct7_5  = r_data.funct7_5;
    assign ex_alusrc    = r_ctrl.alusrc;
    assign ex_memtoreg  = r_ctrl.memtoreg;
    assign ex_regwrite  = r_ctrl.regwrite;
    assign ex_memread   = r_ctrl.memread;
    assign ex_memwrite  = r_ctrl.memwrite;
    assign ex_aluop     = r_ctrl.aluop;
    assign stall_cycles = r_stall_cnt;

    logic w_unused;
    assign w_unused = w_uses_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued
// as ID stimulus is applied and compared after each clock edge.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic [6:0]  ctl;
    } ex_t;

    localparam logic [6:0] C_ADD  = 7'b0010010;
    localparam logic [6:0] C_LW   = 7'b1111000;
    localparam logic [6:0] C_ADDI = 7'b1010010;
    localparam logic [6:0] C_SW   = 7'b1000100;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]       id_funct3;
    logic             id_funct7_5;
    logic             id_alusrc, id_memtoreg, id_regwrite;
    logic             id_memread, id_memwrite;
    logic [1:0]       id_aluop;
    logic             flush;
    logic             ex_ready;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7_5;
    logic             ex_alusrc, ex_memtoreg, ex_regwrite;
    logic             ex_memread, ex_memwrite;
    logic [1:0]       ex_aluop;
    logic             id_stall;
    logic [CNT_W-1:0] stall_cycles;

    int n_chk = 0;
    int n_err = 0;

    ex_t            m = '0;
    logic [CNT_W-1:0] mcnt = '0;
    ex_t            q[$];

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_aluop(id_aluop),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
        .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_aluop(ex_aluop),
        .id_stall(id_stall), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag,
                       input logic [159:0] obs,
                       input logic [159:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [6:0] ctl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h5A5A_0000;
        id_imm      = ~pc;
        id_funct3   = pc[4:2];
        id_funct7_5 = pc[5];
        {id_alusrc, id_memtoreg, id_regwrite,
         id_memread, id_memwrite, id_aluop} = ctl;
    endtask

    // One clock: check id_stall, queue the expected EX state, compare.
    task automatic cyc(input logic exp_stall, input string tag);
        ex_t  nx;
        ex_t  o;
        logic adv, lu, u2;
        #1;
        chk({tag, "_stall"}, id_stall, exp_stall);
        adv = !m.v | ex_ready;
        u2  = !id_alusrc | id_memwrite;
        lu  = id_valid & m.v & m.ctl[3] & m.ctl[4] & (m.rd != 5'd0)
            & ((m.rd == id_rs1) | (u2 & (m.rd == id_rs2)));
        if (rst) nx = '0;
        else if (!adv) nx = m;
        else if (flush | lu | !id_valid) nx = '0;
        else nx = '{v: 1'b1, pc: id_pc, a: id_rs1_data,
                    b: id_rs2_data, imm: id_imm, rs1: id_rs1,
                    rs2: id_rs2, rd: id_rd, f3: id_funct3,
                    f7: id_funct7_5,
                    ctl: {id_alusrc, id_memtoreg, id_regwrite,
                          id_memread, id_memwrite, id_aluop}};
        if (rst) mcnt = '0;
        else if (exp_stall && mcnt != '1) mcnt = mcnt + 1'b1;
        q.push_back(nx);
        @(posedge clk);
        #1;
        o = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5,
             ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
             ex_memwrite, ex_aluop};
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 1'b0, 1'b1);
        end else begin
            m = q.pop_front();
            chk({tag, "_ex"}, o, m);
        end
        chk({tag, "_cnt"}, stall_cycles, mcnt);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ex_ready = 1'b1;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 7'd0);
        cyc(1'b0, "reset");
        chk("reset_valid", ex_valid, 1'b0);
        chk("reset_cnt0", stall_cycles, 4'd0);
        rst = 1'b0;

        // Back-to-back independent ADDs.
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, 32'h100 + 32'(4 * i), 5'(i + 1),
                   5'(i + 10), 5'(i + 20), C_ADD);
            cyc(1'b0, "add");
        end
        chk("add_last_pc", ex_pc, 32'h10C);
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 7'h7F);
        cyc(1'b0, "idle_garbage");
        chk("idle_regwrite", ex_regwrite, 1'b0);
        chk("s1_cnt", stall_cycles, 4'd0);

        // LW x5 ; ADD x6,x5,x7
        set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, C_LW);
        cyc(1'b0, "lw");
        set_id(1'b1, 32'h204, 5'd5, 5'd7, 5'd6, C_ADD);
        cyc(1'b1, "lu_add");
        chk("lu_bubble_v", ex_valid, 1'b0);
        chk("lu_bubble_rw", ex_regwrite, 1'b0);
        cyc(1'b0, "lu_add2");
        chk("lu_add_pc", ex_pc, 32'h204);
        chk("s2_cnt", stall_cycles, 4'd1);

        // rd=x0 load, immediate consumer, store consumer.
        set_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd0, C_LW);
        cyc(1'b0, "lw_x0");
        set_id(1'b1, 32'h304, 5'd0, 5'd1, 5'd6, C_ADD);
        cyc(1'b0, "add_x0");
        set_id(1'b1, 32'h308, 5'd1, 5'd0, 5'd5, C_LW);
        cyc(1'b0, "lw_b");
        set_id(1'b1, 32'h30C, 5'd9, 5'd5, 5'd6, C_ADDI);
        cyc(1'b0, "addi");
        set_id(1'b1, 32'h310, 5'd1, 5'd0, 5'd5, C_LW);
        cyc(1'b0, "lw_c");
        set_id(1'b1, 32'h314, 5'd2, 5'd5, 5'd0, C_SW);
        cyc(1'b1, "sw_lu");
        cyc(1'b0, "sw");
        chk("sw_memwrite", ex_memwrite, 1'b1);
        chk("s3_cnt", stall_cycles, 4'd2);

        // Three cycles of EX backpressure.
        set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd3, C_ADD);
        cyc(1'b0, "bp_add");
        set_id(1'b1, 32'h404, 5'd4, 5'd5, 5'd6, C_ADD);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, "bp_hold");
        chk("bp_held_pc", ex_pc, 32'h400);
        ex_ready = 1'b1;
        cyc(1'b0, "bp_rel");
        chk("bp_rel_pc", ex_pc, 32'h404);
        chk("s4_cnt", stall_cycles, 4'd5);

        // Flush over load-use, then flush while EX held.
        set_id(1'b1, 32'h500, 5'd1, 5'd0, 5'd5, C_LW);
        cyc(1'b0, "fl_lw");
        set_id(1'b1, 32'h504, 5'd5, 5'd7, 5'd6, C_ADD);
        flush = 1'b1;
        cyc(1'b0, "fl_lu");
        chk("fl_bubble_v", ex_valid, 1'b0);
        flush = 1'b0;
        set_id(1'b1, 32'h508, 5'd1, 5'd2, 5'd3, C_ADD);
        cyc(1'b0, "fl_add");
        set_id(1'b1, 32'h50C, 5'd1, 5'd2, 5'd4, C_ADD);
        ex_ready = 1'b0;
        flush = 1'b1;
        cyc(1'b0, "fl_hold");
        chk("fl_hold_pc", ex_pc, 32'h508);
        chk("fl_hold_v", ex_valid, 1'b1);
        flush = 1'b0;
        ex_ready = 1'b1;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 7'd0);
        cyc(1'b0, "fl_idle");
        chk("s5_cnt", stall_cycles, 4'd5);

        // Reset during a backpressure stall.
        set_id(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, C_ADD);
        cyc(1'b0, "rs_add");
        set_id(1'b1, 32'h604, 5'd1, 5'd2, 5'd4, C_ADD);
        ex_ready = 1'b0;
        cyc(1'b1, "rs_hold");
        rst = 1'b1;
        cyc(1'b1, "rs_rst");
        rst = 1'b0;
        chk("rs_valid", ex_valid, 1'b0);
        chk("rs_pc", ex_pc, 32'h0);
        chk("rs_cnt", stall_cycles, 4'd0);

        // Saturate the 4-bit counter with 17 stall cycles.
        ex_ready = 1'b1;
        set_id(1'b1, 32'h700, 5'd1, 5'd2, 5'd3, C_ADD);
        cyc(1'b0, "sat_add");
        set_id(1'b1, 32'h704, 5'd1, 5'd2, 5'd4, C_ADD);
        ex_ready = 1'b0;
        for (int i = 0; i < 17; i++) cyc(1'b1, "sat_hold");
        chk("sat_cnt", stall_cycles, 4'd15);
        ex_ready = 1'b1;
        cyc(1'b0, "sat_rel");
        chk("sat_cnt_hold", stall_cycles, 4'd15);
        chk("sat_rel_pc", ex_pc, 32'h704);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
